abr_prim_debounce: RTL and testbench

//  Per-lane digital debouncer/glitch filter for slow, noisy, already-synchronous level inputs
//  (straps, external request lines, status bits).

---
 rtl/abr_prim_debounce.sv | 122 ++++++++++++
 tb/tb_abr_prim_debounce.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/abr_prim_debounce.sv
// Per-lane debouncer / glitch filter for slow, already-synchronous level inputs.
// A lane commits a new level on q_o only after d_i has differed from q_o for
// thresh_i+1 consecutive sampling edges; shorter glitches never reach q_o.
// Optional build macro ABR_PRIM_DEBOUNCE_EDGE_OUT_EN adds registered one-cycle
// pulses that fire in the same cycle q_o takes a new value.
module abr_prim_debounce #(
  parameter int unsigned      Width      = 1,
  parameter int unsigned      CntWidth   = 8,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [CntWidth-1:0] thresh_i,
  input  logic [Width-1:0]    d_i,
  output logic [Width-1:0]    q_o,
  output logic [Width-1:0]    busy_o
`ifdef ABR_PRIM_DEBOUNCE_EDGE_OUT_EN
  ,
  output logic [Width-1:0]    q_posedge_pulse_o,
  output logic [Width-1:0]    q_negedge_pulse_o
`endif
);

  typedef enum logic {StIdle, StFilter} state_e;

  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  state_e              state_q [Width];
  state_e              state_d [Width];
  logic [CntWidth-1:0] cnt_q   [Width];
  logic [CntWidth-1:0] cnt_d   [Width];
  logic [Width-1:0]    q_q, q_d;
  logic [Width-1:0]    commit;

  // Per-lane next state; commit marks the edge at which q_o adopts d_i.
  always_comb begin
    for (int i = 0; i < Width; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      commit[i]  = 1'b0;
      case (state_q[i])
        StIdle: begin
          cnt_d[i] = '0;
          if (en_i && (d_i[i] != q_q[i])) begin
            if (thresh_i == '0) begin
              commit[i] = 1'b1;
            end else begin
              state_d[i] = StFilter;
              cnt_d[i]   = CntOne;
            end
          end
        end
        StFilter: begin
          // Abort and bounce-back take priority over the threshold check.
          if (!en_i || (d_i[i] == q_q[i])) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= thresh_i) begin
            commit[i]  = 1'b1;
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase
    end
    q_d = (q_q & ~commit) | (d_i & commit);
  end

  // Lane state, counters and filtered level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= ResetValue;
      for (int i = 0; i < Width; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
    end else begin
      q_q <= q_d;
      for (int i = 0; i < Width; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Busy is a direct decode of the registered lane state.
  always_comb begin
    for (int i = 0; i < Width; i++) begin
      busy_o[i] = (state_q[i] == StFilter);
    end
  end

  assign q_o = q_q;

`ifdef ABR_PRIM_DEBOUNCE_EDGE_OUT_EN
  logic [Width-1:0] pos_q, neg_q;

  // Pulses register alongside q_o so they coincide with the new level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q <= '0;
      neg_q <= '0;
    end else begin
      pos_q <= commit & d_i;
      neg_q <= commit & ~d_i;
    end
  end

  assign q_posedge_pulse_o = pos_q;
  assign q_negedge_pulse_o = neg_q;
`else
  // Edge outputs not built; downstream edge detection is external.
`endif

endmodule

// File: tb/tb_abr_prim_debounce.sv
// Scoreboard bench for abr_prim_debounce (Width=2, ResetValue=2'b10).
// Stimulus pushes the hand-computed post-edge response; a monitor pops and compares.
module tb_abr_prim_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] thr;
  logic [1:0] d;
  logic [1:0] q;
  logic [1:0] busy;
`ifdef ABR_PRIM_DEBOUNCE_EDGE_OUT_EN
  logic [1:0] pos;
  logic [1:0] neg;
`endif

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [1:0] q;
    logic [1:0] busy;
    logic [1:0] pos;
    logic [1:0] neg;
    string      name;
  } exp_t;

  exp_t sb[$];

  abr_prim_debounce #(
    .Width     (2),
    .CntWidth  (8),
    .ResetValue(2'b10)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .thresh_i(thr),
    .d_i     (d),
    .q_o     (q),
    .busy_o  (busy)
`ifdef ABR_PRIM_DEBOUNCE_EDGE_OUT_EN
    ,
    .q_posedge_pulse_o(pos),
    .q_negedge_pulse_o(neg)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic check_all(input exp_t e);
    cmp({e.name, " q"}, q, e.q);
    cmp({e.name, " busy"}, busy, e.busy);
`ifdef ABR_PRIM_DEBOUNCE_EDGE_OUT_EN
    cmp({e.name, " pos"}, pos, e.pos);
    cmp({e.name, " neg"}, neg, e.neg);
`endif
  endtask

  // Monitor: one expected entry per clock edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_all(e);
      end
    end
  end

  // Drive inputs mid-cycle (optionally pulsing async reset), then queue the
  // expected state after the following rising edge.
  task automatic step(input logic [1:0] di, input logic eni, input logic [7:0] thri,
                      input logic rst_pulse, input logic [1:0] eq, input logic [1:0] eb,
                      input logic [1:0] ep, input logic [1:0] en_exp, input string name);
    exp_t e;
    @(negedge clk);
    d   = di;
    en  = eni;
    thr = thri;
    if (rst_pulse) begin
      #1 rst = 1'b1;
      #1;
      e = '{q: 2'b10, busy: 2'b00, pos: 2'b00, neg: 2'b00, name: {name, " async-rst"}};
      check_all(e);
      #1 rst = 1'b0;
    end
    @(posedge clk);
    e = '{q: eq, busy: eb, pos: ep, neg: en_exp, name: name};
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    en  = 1'b1;
    thr = 8'd3;
    d   = 2'b10;
    #13;
    e = '{q: 2'b10, busy: 2'b00, pos: 2'b00, neg: 2'b00, name: "reset"};
    check_all(e);
    @(negedge clk);
    rst = 1'b0;

    // Step with thresh 3: busy for 3 cycles, commit on the 4th edge.
    step(2'b11, 1'b1, 8'd3, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, "step e0");
    step(2'b11, 1'b1, 8'd3, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, "step e1");
    step(2'b11, 1'b1, 8'd3, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, "step e2");
    step(2'b11, 1'b1, 8'd3, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, "step commit");
    step(2'b11, 1'b1, 8'd3, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, "step hold");
    // en low in idle with d != q: hold.
    step(2'b10, 1'b0, 8'd0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, "en low idle");
    // thresh 0 brings lane0 back low in one cycle.
    step(2'b10, 1'b1, 8'd0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, "thr0 fall");

    // 3-cycle glitch with thresh 3 never reaches q.
    step(2'b11, 1'b1, 8'd3, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, "glitch e0");
    step(2'b11, 1'b1, 8'd3, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, "glitch e1");
    step(2'b11, 1'b1, 8'd3, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, "glitch e2");
    step(2'b10, 1'b1, 8'd3, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, "glitch bounce");
    step(2'b10, 1'b1, 8'd3, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, "glitch idle");

    // thresh 0 toggling: plain register, alternating pulses.
    step(2'b11, 1'b1, 8'd0, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, "tog 1");
    step(2'b10, 1'b1, 8'd0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, "tog 2");
    step(2'b11, 1'b1, 8'd0, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, "tog 3");
    step(2'b10, 1'b1, 8'd0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, "tog 4");

    // thresh 5, en dropped at cnt=3 then restored: restart, commit 6 edges later.
    step(2'b11, 1'b1, 8'd5, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, "abort c1");
    step(2'b11, 1'b1, 8'd5, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, "abort c2");
    step(2'b11, 1'b1, 8'd5, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, "abort c3");
    step(2'b11, 1'b0, 8'd5, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, "abort en0");
    step(2'b11, 1'b1, 8'd5, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, "restart c1");
    for (int k = 2; k <= 5; k++) begin
      step(2'b11, 1'b1, 8'd5, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, $sformatf("restart c%0d", k));
    end
    step(2'b11, 1'b1, 8'd5, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, "restart commit");

    // Two lanes, thresh 2, stepped one cycle apart: commits one cycle apart.
    step(2'b10, 1'b1, 8'd2, 1'b0, 2'b11, 2'b01, 2'b00, 2'b00, "lanes e0");
    step(2'b00, 1'b1, 8'd2, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, "lanes e1");
    step(2'b00, 1'b1, 8'd2, 1'b0, 2'b10, 2'b10, 2'b00, 2'b01, "lanes c0");
    step(2'b00, 1'b1, 8'd2, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, "lanes c1");
    // Repeat run, reset mid-filter: fresh 3-edge window needed afterwards.
    step(2'b01, 1'b1, 8'd2, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, "rep e0");
    step(2'b11, 1'b1, 8'd2, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, "rep e1");
    step(2'b11, 1'b1, 8'd2, 1'b1, 2'b10, 2'b01, 2'b00, 2'b00, "post-rst e0");
    step(2'b11, 1'b1, 8'd2, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, "post-rst e1");
    step(2'b11, 1'b1, 8'd2, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, "post-rst commit");

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
